// File: rtl/trigger_sequencer.sv
// trigger_sequencer: qualifies the routed trigger with a synchronized rising
// edge, waits a programmable delay, then emits a programmable-width pulse.
// Configured over the reg_* bus at a single address, byte-selected by reg_bytecnt.
// Optional build macro TRIGSEQ_COUNT_EN: builds the saturating pulse counter
// behind byte 6; without it byte 6 reads 0 and ignores writes.
module trigger_sequencer #(
   parameter int unsigned ADDR = 56
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic [5:0]  reg_address,
   input  logic [15:0] reg_bytecnt,
   input  logic [7:0]  reg_datai,
   output logic [7:0]  reg_datao,
   input  logic        reg_read,
   input  logic        reg_write,
   input  logic        reg_addrvalid,
   input  logic [5:0]  reg_hypaddress,
   output logic [15:0] reg_hyplen,
   input  logic        trigger_i,
   output logic        trigger_o,
   output logic        armed_o,
   output logic        busy_o
);

   localparam int unsigned AW  = 6;
   localparam int unsigned DW  = 8;
   localparam int unsigned CW  = 16;
   localparam int unsigned BCW = 16;
   localparam int unsigned REG_LEN = 7;

   localparam logic [BCW-1:0] BYTE_CTRL    = BCW'(0);
   localparam logic [BCW-1:0] BYTE_DELAY_L = BCW'(1);
   localparam logic [BCW-1:0] BYTE_DELAY_H = BCW'(2);
   localparam logic [BCW-1:0] BYTE_WIDTH_L = BCW'(3);
   localparam logic [BCW-1:0] BYTE_WIDTH_H = BCW'(4);
   localparam logic [BCW-1:0] BYTE_STATUS  = BCW'(5);
   localparam logic [BCW-1:0] BYTE_COUNT   = BCW'(6);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DELAY = 2'd2,
      ST_PULSE = 2'd3
   } state_e;

   state_e          state_q, state_d;

   // register file
   logic            arm_q;
   logic            oneshot_q;
   logic [CW-1:0]   delay_q;
   logic [CW-1:0]   width_q;
   logic [CW-1:0]   sh_delay_q;
   logic [CW-1:0]   sh_width_q;
   logic [DW-1:0]   count_c;

   // datapath
   logic [CW-1:0]   dcnt_q;
   logic [CW-1:0]   wcnt_q;
   logic            trig_meta_q;
   logic            trig_sync_q;
   logic            trig_prev_q;
   logic            trigger_q, trigger_d;
   logic            armed_q, armed_d;
   logic            busy_q, busy_d;

   // bus read path
   logic            valid_q;
   logic [DW-1:0]   rdata_q, rdata_d;

   // decoded strobes
   logic            sel_c;
   logic            wr_sel_c;
   logic            ctrl_we_c;
   logic            arm_we_c;
   logic            disarm_c;
   logic            trig_edge_c;
   logic            accept_c;
   logic            pulse_end_c;

   assign sel_c       = reg_addrvalid && (reg_address == AW'(ADDR));
   assign wr_sel_c    = reg_write && sel_c;
   assign ctrl_we_c   = wr_sel_c && (reg_bytecnt == BYTE_CTRL);
   assign arm_we_c    = ctrl_we_c && reg_datai[0];
   assign disarm_c    = ctrl_we_c && !reg_datai[0];
   assign trig_edge_c = trig_sync_q && !trig_prev_q;
   // An edge is taken only once the previous pulse has fully left trigger_o.
   assign accept_c    = (state_q == ST_ARMED) && trig_edge_c && !trigger_q && !disarm_c;
   assign pulse_end_c = (state_q == ST_PULSE) && (wcnt_q == CW'(1)) && !disarm_c;

   // Two-flop synchronizer plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (reset_i) begin
         trig_meta_q <= 1'b0;
         trig_sync_q <= 1'b0;
         trig_prev_q <= 1'b0;
      end else begin
         trig_meta_q <= trigger_i;
         trig_sync_q <= trig_meta_q;
         trig_prev_q <= trig_sync_q;
      end
   end

   // Visible CTRL/DELAY/WIDTH registers; ONESHOT completion clears ARM
   always_ff @(posedge clk) begin
      if (reset_i) begin
         arm_q     <= 1'b0;
         oneshot_q <= 1'b0;
         delay_q   <= '0;
         width_q   <= CW'(1);
      end else begin
         if (ctrl_we_c) begin
            arm_q     <= reg_datai[0];
            oneshot_q <= reg_datai[1];
         end else if (pulse_end_c && oneshot_q) begin
            arm_q <= 1'b0;
         end
         if (wr_sel_c && (reg_bytecnt == BYTE_DELAY_L)) delay_q[7:0]  <= reg_datai;
         if (wr_sel_c && (reg_bytecnt == BYTE_DELAY_H)) delay_q[15:8] <= reg_datai;
         if (wr_sel_c && (reg_bytecnt == BYTE_WIDTH_L)) width_q[7:0]  <= reg_datai;
         if (wr_sel_c && (reg_bytecnt == BYTE_WIDTH_H)) width_q[15:8] <= reg_datai;
      end
   end

   // Shadow copies taken at arm time so later DELAY/WIDTH writes wait for the next arm
   always_ff @(posedge clk) begin
      if (reset_i) begin
         sh_delay_q <= '0;
         sh_width_q <= CW'(1);
      end else if (arm_we_c && (state_q == ST_IDLE)) begin
         sh_delay_q <= delay_q;
         sh_width_q <= (width_q == '0) ? CW'(1) : width_q;
      end
   end

   // Delay and width down-counters, both loaded when an edge is accepted
   always_ff @(posedge clk) begin
      if (reset_i) begin
         dcnt_q <= '0;
         wcnt_q <= '0;
      end else begin
         unique case (state_q)
            ST_ARMED: begin
               if (accept_c) begin
                  dcnt_q <= sh_delay_q;
                  wcnt_q <= sh_width_q;
               end
            end
            ST_DELAY: dcnt_q <= dcnt_q - CW'(1);
            ST_PULSE: wcnt_q <= wcnt_q - CW'(1);
            default:  ;
         endcase
      end
   end

`ifdef TRIGSEQ_COUNT_EN
   logic [DW-1:0] count_q;
   logic          count_clr_c;

   assign count_clr_c = wr_sel_c && (reg_bytecnt == BYTE_COUNT);

   // Saturating count of completed pulses; a clear beats a coincident increment
   always_ff @(posedge clk) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (count_clr_c) begin
         count_q <= '0;
      end else if (pulse_end_c && (count_q != {DW{1'b1}})) begin
         count_q <= count_q + DW'(1);
      end
   end

   assign count_c = count_q;
`else
   assign count_c = '0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state; a disarm write overrides every other transition
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arm_we_c) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (accept_c) state_d = (sh_delay_q == '0) ? ST_PULSE : ST_DELAY;
         end
         ST_DELAY: begin
            if (dcnt_q == CW'(1)) state_d = ST_PULSE;
         end
         ST_PULSE: begin
            if (wcnt_q == CW'(1)) state_d = oneshot_q ? ST_IDLE : ST_ARMED;
         end
         default: state_d = ST_IDLE;
      endcase
      if (disarm_c) state_d = ST_IDLE;
   end

   // FSM outputs; trigger_o trails the PULSE state by one cycle, status flags track the state
   always_comb begin
      trigger_d = 1'b0;
      armed_d   = 1'b0;
      busy_d    = 1'b0;
      if ((state_q == ST_PULSE) && !disarm_c) trigger_d = 1'b1;
      if (state_d == ST_ARMED) armed_d = 1'b1;
      if ((state_d == ST_DELAY) || (state_d == ST_PULSE)) busy_d = 1'b1;
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset_i) begin
         trigger_q <= 1'b0;
         armed_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         trigger_q <= trigger_d;
         armed_q   <= armed_d;
         busy_q    <= busy_d;
      end
   end

   assign trigger_o = trigger_q;
   assign armed_o   = armed_q;
   assign busy_o    = busy_q;

   // Read-data mux by byte index
   always_comb begin
      rdata_d = '0;
      case (reg_bytecnt)
         BYTE_CTRL:    rdata_d = {6'd0, oneshot_q, arm_q};
         BYTE_DELAY_L: rdata_d = delay_q[7:0];
         BYTE_DELAY_H: rdata_d = delay_q[15:8];
         BYTE_WIDTH_L: rdata_d = width_q[7:0];
         BYTE_WIDTH_H: rdata_d = width_q[15:8];
         BYTE_STATUS:  rdata_d = {5'd0, trig_sync_q, state_q};
         BYTE_COUNT:   rdata_d = count_c;
         default:      rdata_d = '0;
      endcase
   end

   // Bus read registers: select flag every cycle, data on the read strobe
   always_ff @(posedge clk) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         valid_q <= sel_c;
         if (reg_read) rdata_q <= rdata_d;
      end
   end

   assign reg_datao  = valid_q ? rdata_q : '0;
   assign reg_hyplen = (reg_hypaddress == AW'(ADDR)) ? 16'(REG_LEN) : '0;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed bench for trigger_sequencer with hand-computed
// expectations. Latencies are counted from the clock edge after trigger_i rises:
// sync takes 2 edges, edge detect 1 more (E), so trigger_o rises 4+DELAY edges later.
module tb_trigger_sequencer;

   localparam int unsigned ADDR  = 56;
   localparam int          LIMIT = 70000;

`ifdef TRIGSEQ_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic        clk;
   logic        reset_i;
   logic [5:0]  reg_address;
   logic [15:0] reg_bytecnt;
   logic [7:0]  reg_datai;
   logic [7:0]  reg_datao;
   logic        reg_read;
   logic        reg_write;
   logic        reg_addrvalid;
   logic [5:0]  reg_hypaddress;
   logic [15:0] reg_hyplen;
   logic        trigger_i;
   logic        trigger_o;
   logic        armed_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int pulses_seen = 0;
   logic trig_seen_q = 1'b0;

   trigger_sequencer #(.ADDR(ADDR)) dut (
      .clk            (clk),
      .reset_i        (reset_i),
      .reg_address    (reg_address),
      .reg_bytecnt    (reg_bytecnt),
      .reg_datai      (reg_datai),
      .reg_datao      (reg_datao),
      .reg_read       (reg_read),
      .reg_write      (reg_write),
      .reg_addrvalid  (reg_addrvalid),
      .reg_hypaddress (reg_hypaddress),
      .reg_hyplen     (reg_hyplen),
      .trigger_i      (trigger_i),
      .trigger_o      (trigger_o),
      .armed_o        (armed_o),
      .busy_o         (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count trigger_o rising edges, sampled mid-cycle
   always @(negedge clk) begin
      if (trigger_o && !trig_seen_q) pulses_seen = pulses_seen + 1;
      trig_seen_q = trigger_o;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reg_wr(input logic [15:0] bytecnt, input logic [7:0] data);
      reg_address   = 6'(ADDR);
      reg_addrvalid = 1'b1;
      reg_bytecnt   = bytecnt;
      reg_datai     = data;
      reg_write     = 1'b1;
      tick();
      reg_write     = 1'b0;
      reg_addrvalid = 1'b0;
   endtask

   task automatic reg_rd(input logic [15:0] bytecnt, output logic [7:0] data);
      reg_address   = 6'(ADDR);
      reg_addrvalid = 1'b1;
      reg_bytecnt   = bytecnt;
      reg_read      = 1'b1;
      tick();
      reg_read      = 1'b0;
      data          = reg_datao;
      reg_addrvalid = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [15:0] bytecnt, input logic [7:0] exp);
      logic [7:0] d;
      reg_rd(bytecnt, d);
      check(tag, 32'(d), 32'(exp));
   endtask

   // Raise trigger_i and count edges until trigger_o goes high (-1 on timeout)
   task automatic wait_rise(input int regap, output int lat);
      trigger_i = 1'b1;
      lat = -1;
      for (int i = 1; i <= LIMIT; i++) begin
         tick();
         if (regap > 0 && i == regap / 2) trigger_i = 1'b0;
         if (regap > 0 && i == regap)     trigger_i = 1'b1;
         if (trigger_o) begin
            lat = i;
            break;
         end
      end
   endtask

   // Full pulse: latency to rise, high time, then release trigger_i
   task automatic fire(input int regap, output int lat, output int wid);
      wait_rise(regap, lat);
      wid = -1;
      if (lat > 0) begin
         wid = 1;
         for (int i = 0; i < LIMIT; i++) begin
            tick();
            if (!trigger_o) break;
            wid = wid + 1;
         end
      end
      trigger_i = 1'b0;
      ticks(3);
   endtask

   function automatic logic [7:0] exp_count(input int n);
      if (!COUNT_EN) return 8'd0;
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   int lat;
   int wid;
   int highs;
   int base;
   logic [7:0] d;

   initial begin
      reset_i        = 1'b1;
      reg_address    = '0;
      reg_bytecnt    = '0;
      reg_datai      = '0;
      reg_read       = 1'b0;
      reg_write      = 1'b0;
      reg_addrvalid  = 1'b0;
      reg_hypaddress = '0;
      trigger_i      = 1'b0;
      ticks(3);
      reset_i = 1'b0;
      tick();

      // Reset state
      check("rst_trigger_o", 32'(trigger_o), 32'd0);
      check("rst_armed_o",   32'(armed_o),   32'd0);
      check("rst_busy_o",    32'(busy_o),    32'd0);
      check("rst_datao",     32'(reg_datao), 32'd0);
      rd_check("rst_b0", 16'd0, 8'h00);
      rd_check("rst_b1", 16'd1, 8'h00);
      rd_check("rst_b2", 16'd2, 8'h00);
      rd_check("rst_b3", 16'd3, 8'h01);
      rd_check("rst_b4", 16'd4, 8'h00);
      rd_check("rst_b5", 16'd5, 8'h00);
      rd_check("rst_b6", 16'd6, 8'h00);
      reg_hypaddress = 6'(ADDR);
      #1 check("hyplen_hit", 32'(reg_hyplen), 32'd7);
      reg_hypaddress = 6'd3;
      #1 check("hyplen_miss", 32'(reg_hyplen), 32'd0);
      reg_address = 6'd3; reg_addrvalid = 1'b1; reg_bytecnt = 16'd3; reg_read = 1'b1;
      tick();
      reg_read = 1'b0; reg_addrvalid = 1'b0;
      check("other_addr_datao", 32'(reg_datao), 32'd0);

      // DELAY=0, WIDTH=1, continuous mode
      reg_wr(16'd0, 8'h01);
      check("arm_armed_o", 32'(armed_o), 32'd1);
      rd_check("arm_status", 16'd5, 8'h01);
      fire(0, lat, wid);
      check("d0_latency", 32'(lat), 32'd4);
      check("d0_width",   32'(wid), 32'd1);
      check("d0_rearmed", 32'(armed_o), 32'd1);
      rd_check("d0_count", 16'd6, exp_count(1));

      // DELAY=10, WIDTH=5, ONESHOT; second rise during DELAY is dropped
      reg_wr(16'd0, 8'h00);
      check("disarm_idle", 32'(armed_o), 32'd0);
      reg_wr(16'd1, 8'd10);
      reg_wr(16'd2, 8'd0);
      reg_wr(16'd3, 8'd5);
      reg_wr(16'd4, 8'd0);
      reg_wr(16'd0, 8'h03);
      trigger_i = 1'b1;
      wait_rise(4, lat);
      check("d10_latency", 32'(lat), 32'd14);
      wid = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!trigger_o) break;
         wid = wid + 1;
      end
      check("d10_width", 32'(wid), 32'd5);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (trigger_o) highs = highs + 1;
      end
      check("d10_no_second", 32'(highs), 32'd0);
      check("d10_armed_o",   32'(armed_o), 32'd0);
      check("d10_busy_o",    32'(busy_o),  32'd0);
      rd_check("d10_ctrl",   16'd0, 8'h02);
      rd_check("d10_status", 16'd5, 8'h04);
      trigger_i = 1'b0;
      ticks(3);
      rd_check("d10_count", 16'd6, exp_count(2));

      // WIDTH=0 is taken as 1
      reg_wr(16'd1, 8'd0);
      reg_wr(16'd3, 8'd0);
      reg_wr(16'd0, 8'h03);
      fire(0, lat, wid);
      check("w0_latency", 32'(lat), 32'd4);
      check("w0_width",   32'(wid), 32'd1);
      rd_check("w0_width_reg", 16'd3, 8'h00);

      // DELAY=65535
      reg_wr(16'd1, 8'hFF);
      reg_wr(16'd2, 8'hFF);
      reg_wr(16'd3, 8'd2);
      reg_wr(16'd0, 8'h03);
      fire(0, lat, wid);
      check("dmax_latency", 32'(lat), 32'd65539);
      check("dmax_width",   32'(wid), 32'd2);
      rd_check("dmax_count", 16'd6, exp_count(4));

      // Disarm during DELAY
      reg_wr(16'd1, 8'd20);
      reg_wr(16'd2, 8'd0);
      reg_wr(16'd3, 8'd3);
      reg_wr(16'd0, 8'h01);
      trigger_i = 1'b1;
      ticks(8);
      check("dly_busy_o", 32'(busy_o), 32'd1);
      reg_wr(16'd0, 8'h00);
      check("dly_disarm_trig", 32'(trigger_o), 32'd0);
      check("dly_disarm_busy", 32'(busy_o),    32'd0);
      check("dly_disarm_armed", 32'(armed_o),  32'd0);
      highs = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (trigger_o) highs = highs + 1;
      end
      check("dly_disarm_quiet", 32'(highs), 32'd0);
      trigger_i = 1'b0;
      ticks(3);
      rd_check("dly_disarm_state", 16'd5, 8'h00);

      // Disarm during PULSE
      reg_wr(16'd1, 8'd0);
      reg_wr(16'd3, 8'd10);
      reg_wr(16'd0, 8'h01);
      wait_rise(0, lat);
      check("pls_latency", 32'(lat), 32'd4);
      ticks(2);
      check("pls_still_high", 32'(trigger_o), 32'd1);
      reg_wr(16'd0, 8'h00);
      check("pls_disarm_trig", 32'(trigger_o), 32'd0);
      check("pls_disarm_busy", 32'(busy_o),    32'd0);
      trigger_i = 1'b0;
      ticks(3);
      rd_check("pls_disarm_state", 16'd5, 8'h00);
      rd_check("pls_disarm_count", 16'd6, exp_count(4));

      // 300 pulses in continuous mode, then clear COUNT
      reg_wr(16'd3, 8'd1);
      reg_wr(16'd0, 8'h01);
      base = pulses_seen;
      for (int p = 0; p < 300; p++) begin
         trigger_i = 1'b1;
         ticks(6);
         trigger_i = 1'b0;
         ticks(4);
      end
      check("sat_pulses", 32'(pulses_seen - base), 32'd300);
      rd_check("sat_count", 16'd6, exp_count(304));
      rd_check("sat_status", 16'd5, 8'h01);
      reg_wr(16'd6, 8'hA5);
      rd_check("clr_count", 16'd6, 8'h00);

      // Reset mid-pulse
      reg_wr(16'd0, 8'h00);
      reg_wr(16'd3, 8'd10);
      reg_wr(16'd0, 8'h01);
      wait_rise(0, lat);
      check("rst2_latency", 32'(lat), 32'd4);
      ticks(2);
      reset_i = 1'b1;
      tick();
      check("rst2_trigger_o", 32'(trigger_o), 32'd0);
      check("rst2_armed_o",   32'(armed_o),   32'd0);
      check("rst2_busy_o",    32'(busy_o),    32'd0);
      reset_i   = 1'b0;
      trigger_i = 1'b0;
      ticks(3);
      rd_check("rst2_ctrl",  16'd0, 8'h00);
      rd_check("rst2_width", 16'd3, 8'h01);
      rd_check("rst2_count", 16'd6, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
